sine_rom_scheduler: RTL and testbench
=====================================

# sine_rom_scheduler

Sequencer and arbiter that shares one 64-entry synchronous sine ROM between two PWM width channels (A and B). Each channel has its own tick divider and phase accumulator with programmable step. A round-robin arbiter issues at most one ROM read per cycle and routes the returned sample to the owning channel's width register. Sits between the 100 MHz clock domain's PWM generators and the shared sine ROM.

## Interface
- ADDR_W, 6, ROM address width (64 entries)
- DATA_W, 32, ROM word / width output width
- MAX_A, 1000, channel A tick period in clk100 cycles (>=1)
- MAX_B, 1000, channel B tick period in clk100 cycles (>=1)

- clk100  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable for both tick dividers
- step_a  in  ADDR_W  channel A phase increment, sampled in A's grant cycle
- step_b  in  ADDR_W  channel B phase increment, sampled in B's grant cycle
- rom_en  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM read address, valid while rom_en=1
- rom_data  in  DATA_W  ROM output, valid the cycle after rom_en
- width_a  out  DATA_W  latest sample for channel A
- width_b  out  DATA_W  latest sample for channel B
- valid_a  out  1  one-cycle pulse, width_a just updated
- valid_b  out  1  one-cycle pulse, width_b just updated
- overrun  out  1  sticky: a tick found its channel's request still pending

## Operation
- Reset: tick counters, phases, pending flags, widths, valid_*, rom_en, overrun all 0; round-robin pointer = "last granted B" (A wins the first tie); in-flight ROM read discarded.
- Tick divider per channel: counter increments while en=1, holds while en=0. In the cycle counter==MAX-1 with en=1, tick asserts and counter wraps to 0. MAX=1 ticks every enabled cycle.
- A tick sets the channel's pending flag (registered).
- Arbiter (combinational on registered pending flags and pointer):
  - one pending: grant it
  - both pending: grant the channel not granted last
  - none: rom_en=0, rom_addr holds last value
- Grant cycle: rom_en=1, rom_addr=phase_x. At cycle end: pending_x cleared, phase_x <= (phase_x + step_x) mod 2^ADDR_W, pointer <= x, in-flight owner tag <= x.
- Return: cycle after grant, rom_data captured into width_x at cycle end; valid_x high for the following cycle.
- Tick and grant of same channel in the same cycle: pending stays set, no overrun.
- Tick while pending_x already set and not being granted: request not duplicated (one sample per pending), overrun <= 1, held until rst.
- en=0: no new ticks; already pending requests still drain.
- width_x holds its value between updates; valid_a and valid_b never both high in one cycle.

## Timing
- Tick to rom_en: 1 cycle (tick in cycle T, pending visible T+1, rom_en in T+1 if uncontested).
- rom_en to width_x update: width_x changes at end of grant+1; valid_x high in grant+2.
- Tick-to-valid latency: 3 cycles uncontested, 4 when losing a tie.
- Throughput: one ROM read per cycle; back-to-back grants allowed, pipeline fully overlapped.
- rst asserted in any cycle: all outputs 0 the next cycle; no valid pulse for a read issued before or during reset.

## Test plan
- Reset: hold rst 3 cycles mid-run with a grant in flight -> all outputs 0 next cycle, no valid_* pulse after reset deasserts until a new tick.
- Single channel: MAX_A=4, step_a=1, B idle, en=1 from cycle 0 -> rom_en with rom_addr=0 in cycle 4, valid_a in cycle 6, width_a=ROM[0]; next reads at addr 1,2,3 every 4 cycles.
- Wrap-around: step_a=5 -> successive A addresses 0,5,10,...,60,1,6; width_a matches ROM model each time.
- Tie: MAX_A=MAX_B=4, steps 1 and 2 -> cycle 4 grant A addr 0, cycle 5 grant B addr 0; valid_a cycle 6, valid_b cycle 7; next round A addr 1 then B addr 2.
- Overrun: MAX_A=MAX_B=1 -> grants alternate A,B every cycle, overrun=1 from the second cycle after en, stays 1 until rst.
- en gating: drop en with A pending -> pending A still served once, then no rom_en; counter resumes from held value when en returns.

Source files
------------

// File: rtl/sine_rom_scheduler.sv
// Shares one synchronous 64-entry sine ROM between two PWM width channels.
// Each channel ticks from its own divider, queues one read, and receives the returned sample.
module sine_rom_scheduler #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int MAX_A  = 1000,
  parameter int MAX_B  = 1000
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] step_a,
  input  logic [ADDR_W-1:0] step_b,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] width_a,
  output logic [DATA_W-1:0] width_b,
  output logic              valid_a,
  output logic              valid_b,
  output logic              overrun
);

  localparam int CA_W = (MAX_A > 1) ? $clog2(MAX_A) : 1;
  localparam int CB_W = (MAX_B > 1) ? $clog2(MAX_B) : 1;

  logic [CA_W-1:0]   cnt_a;
  logic [CB_W-1:0]   cnt_b;
  logic              tick_a;
  logic              tick_b;
  logic              pend_a;
  logic              pend_b;
  logic              last_b;
  logic [ADDR_W-1:0] phase_a;
  logic [ADDR_W-1:0] phase_b;
  logic [ADDR_W-1:0] addr_hold;
  logic              gnt_a_p0;
  logic              gnt_b_p0;
  logic              vld_p1;
  logic              own_b_p1;

  assign tick_a = en && (cnt_a == CA_W'(MAX_A - 1));
  assign tick_b = en && (cnt_b == CB_W'(MAX_B - 1));

  always_ff @(posedge clk100) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (en) begin
      cnt_a <= tick_a ? '0 : cnt_a + CA_W'(1);
      cnt_b <= tick_b ? '0 : cnt_b + CB_W'(1);
    end
  end

  // Stage p0: round-robin grant from registered requests; last_b=1 lets A win a tie.
  always_comb begin
    gnt_a_p0 = pend_a && (!pend_b || last_b);
    gnt_b_p0 = pend_b && !gnt_a_p0;
    rom_en   = gnt_a_p0 || gnt_b_p0;
    rom_addr = addr_hold;
    if (gnt_a_p0) begin
      rom_addr = phase_a;
    end else if (gnt_b_p0) begin
      rom_addr = phase_b;
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
      last_b    <= 1'b1;
      overrun   <= 1'b0;
      phase_a   <= '0;
      phase_b   <= '0;
      addr_hold <= '0;
    end else begin
      // A tick coinciding with its own grant re-arms the request instead of overrunning.
      pend_a <= tick_a || (pend_a && !gnt_a_p0);
      pend_b <= tick_b || (pend_b && !gnt_b_p0);
      if ((tick_a && pend_a && !gnt_a_p0) || (tick_b && pend_b && !gnt_b_p0)) begin
        overrun <= 1'b1;
      end
      if (gnt_a_p0) begin
        phase_a <= phase_a + step_a;
      end
      if (gnt_b_p0) begin
        phase_b <= phase_b + step_b;
      end
      if (rom_en) begin
        last_b    <= gnt_b_p0;
        addr_hold <= rom_addr;
      end
    end
  end

  // Stage p1: ROM word returns; capture into the owning channel.
  always_ff @(posedge clk100) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      own_b_p1 <= 1'b0;
    end else begin
      vld_p1   <= rom_en;
      own_b_p1 <= gnt_b_p0;
    end
  end

  // Stage p2: width registers and one-cycle update strobes.
  always_ff @(posedge clk100) begin
    if (rst) begin
      width_a <= '0;
      width_b <= '0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
    end else begin
      valid_a <= vld_p1 && !own_b_p1;
      valid_b <= vld_p1 && own_b_p1;
      if (vld_p1 && !own_b_p1) begin
        width_a <= rom_data;
      end
      if (vld_p1 && own_b_p1) begin
        width_b <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sine_rom_scheduler.sv
// Bench for sine_rom_scheduler: two instances (4/4 and 3/1 tick periods) driven by shared
// random stimulus, compared every cycle against a behavioural model of ticks, requests and reads.
module tb_sine_rom_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [5:0]  step_a;
  logic [5:0]  step_b;

  logic        rom_en_d  [2];
  logic [5:0]  rom_addr_d[2];
  logic [31:0] rom_data_d[2] = '{32'd0, 32'd0};
  logic [31:0] width_a_d [2];
  logic [31:0] width_b_d [2];
  logic        valid_a_d [2];
  logic        valid_b_d [2];
  logic        overrun_d [2];

  logic [31:0] rom [64];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sine_rom_scheduler #(.ADDR_W(6), .DATA_W(32), .MAX_A(4), .MAX_B(4)) dut0 (
    .clk100(clk), .rst(rst), .en(en), .step_a(step_a), .step_b(step_b),
    .rom_en(rom_en_d[0]), .rom_addr(rom_addr_d[0]), .rom_data(rom_data_d[0]),
    .width_a(width_a_d[0]), .width_b(width_b_d[0]),
    .valid_a(valid_a_d[0]), .valid_b(valid_b_d[0]), .overrun(overrun_d[0])
  );

  sine_rom_scheduler #(.ADDR_W(6), .DATA_W(32), .MAX_A(3), .MAX_B(1)) dut1 (
    .clk100(clk), .rst(rst), .en(en), .step_a(step_a), .step_b(step_b),
    .rom_en(rom_en_d[1]), .rom_addr(rom_addr_d[1]), .rom_data(rom_data_d[1]),
    .width_a(width_a_d[1]), .width_b(width_b_d[1]),
    .valid_a(valid_a_d[1]), .valid_b(valid_b_d[1]), .overrun(overrun_d[1])
  );

  // Synchronous ROM: word appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rom_en_d[0]) rom_data_d[0] <= rom[rom_addr_d[0]];
    if (rom_en_d[1]) rom_data_d[1] <= rom[rom_addr_d[1]];
  end

  // Reference model state, per instance k and channel c (0=A, 1=B).
  int          maxv[2][2] = '{'{4, 4}, '{3, 1}};
  int          ecnt[2][2];
  bit          pend[2][2];
  int          last[2];
  logic [5:0]  phase[2][2];
  logic [5:0]  hold[2];
  bit          infl[2];
  int          own[2];
  logic [5:0]  infl_addr[2];
  logic [31:0] wid[2][2];
  bit          vld[2][2];
  bit          ovr[2];
  bit          known = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int arb(input int k);
    if (pend[k][0] && pend[k][1]) return 1 - last[k];
    if (pend[k][0]) return 0;
    if (pend[k][1]) return 1;
    return -1;
  endfunction

  task automatic model_check(input int k);
    int g;
    if (!known) return;
    g = arb(k);
    chk_eq($sformatf("rom_en%0d", k), 64'(rom_en_d[k]), 64'(g >= 0));
    chk_eq($sformatf("rom_addr%0d", k), 64'(rom_addr_d[k]), 64'((g >= 0) ? phase[k][g] : hold[k]));
    chk_eq($sformatf("width_a%0d", k), 64'(width_a_d[k]), 64'(wid[k][0]));
    chk_eq($sformatf("width_b%0d", k), 64'(width_b_d[k]), 64'(wid[k][1]));
    chk_eq($sformatf("valid_a%0d", k), 64'(valid_a_d[k]), 64'(vld[k][0]));
    chk_eq($sformatf("valid_b%0d", k), 64'(valid_b_d[k]), 64'(vld[k][1]));
    chk_eq($sformatf("overrun%0d", k), 64'(overrun_d[k]), 64'(ovr[k]));
  endtask

  task automatic model_step(input int k);
    int g;
    bit t[2];
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        ecnt[k][c] = 0; pend[k][c] = 0; phase[k][c] = '0; wid[k][c] = '0; vld[k][c] = 0;
      end
      last[k] = 1; hold[k] = '0; infl[k] = 0; own[k] = 0; infl_addr[k] = '0; ovr[k] = 0;
      return;
    end
    g = arb(k);
    for (int c = 0; c < 2; c++) begin
      t[c] = en && ((ecnt[k][c] % maxv[k][c]) == maxv[k][c] - 1);
      if (en) ecnt[k][c]++;
      if (t[c] && pend[k][c] && g != c) ovr[k] = 1;
      pend[k][c] = t[c] || (pend[k][c] && g != c);
      vld[k][c] = infl[k] && own[k] == c;
      if (vld[k][c]) wid[k][c] = rom[infl_addr[k]];
    end
    if (g >= 0) begin
      infl_addr[k] = phase[k][g];
      hold[k] = phase[k][g];
      phase[k][g] = phase[k][g] + ((g == 1) ? step_b : step_a);
      last[k] = g;
      infl[k] = 1;
      own[k] = g;
    end else begin
      infl[k] = 0;
    end
  endtask

  task automatic cyc_begin(input bit r, input bit e, input logic [5:0] sa, input logic [5:0] sb);
    rst = r; en = e; step_a = sa; step_b = sb;
    @(negedge clk);
    model_check(0);
    model_check(1);
  endtask

  task automatic cyc_end();
    model_step(0);
    model_step(1);
    if (rst) known = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rst_left;
    bit r;
    bit e;
    logic [5:0] sa;
    logic [5:0] sb;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rst = 1'b1; en = 1'b0; step_a = '0; step_b = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++) begin cyc_begin(1, 0, 1, 2); cyc_end(); end
    // Tie on instance 0 and early overrun on instance 1; cycle 0 is the first enabled cycle.
    for (int i = 0; i < 40; i++) begin
      cyc_begin(0, 1, 1, 2);
      if (i == 0) chk_eq("reset_outputs", 64'({rom_en_d[0], width_a_d[0], valid_a_d[0], overrun_d[0]}), 64'd0);
      if (i == 4) chk_eq("tie_grant_a", 64'({rom_en_d[0], rom_addr_d[0]}), 64'({1'b1, 6'd0}));
      if (i == 5) chk_eq("tie_grant_b", 64'({rom_en_d[0], rom_addr_d[0]}), 64'({1'b1, 6'd0}));
      if (i == 6) chk_eq("tie_valid_a", 64'({valid_a_d[0], valid_b_d[0], width_a_d[0]}), 64'({2'b10, rom[0]}));
      if (i == 7) chk_eq("tie_valid_b", 64'({valid_a_d[0], valid_b_d[0], width_b_d[0]}), 64'({2'b01, rom[0]}));
      if (i == 8) chk_eq("round2_a", 64'(rom_addr_d[0]), 64'd1);
      if (i == 9) chk_eq("round2_b", 64'(rom_addr_d[0]), 64'd2);
      if (i == 3) chk_eq("no_overrun_yet", 64'(overrun_d[1]), 64'd0);
      if (i == 4) chk_eq("overrun_set", 64'(overrun_d[1]), 64'd1);
      cyc_end();
    end

    // Wrap-around with a single channel.
    for (int i = 0; i < 2; i++) begin cyc_begin(1, 0, 5, 0); cyc_end(); end
    for (int i = 0; i < 80; i++) begin cyc_begin(0, 1, 5, 0); cyc_end(); end

    // Reset held 3 cycles with reads in flight, then idle: no stray valid pulse.
    for (int i = 0; i < 3; i++) begin cyc_begin(1, 1, 5, 0); cyc_end(); end
    for (int i = 0; i < 5; i++) begin
      cyc_begin(0, 0, 5, 0);
      chk_eq("post_rst_quiet", 64'({valid_a_d[0], valid_b_d[0], valid_a_d[1], valid_b_d[1], rom_en_d[0]}), 64'd0);
      cyc_end();
    end

    // Randomized run: sparse resets, en gating, step changes.
    rst_left = 0;
    sa = 6'($urandom); sb = 6'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if (rst_left > 0) begin
        r = 1; rst_left--;
      end else if ($urandom_range(0, 249) == 0) begin
        r = 1; rst_left = $urandom_range(0, 2);
      end else begin
        r = 0;
      end
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) sa = 6'($urandom);
      if ($urandom_range(0, 15) == 0) sb = 6'($urandom);
      cyc_begin(r, e, sa, sb);
      cyc_end();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
